// File: rtl/me_pixel_feeder.sv
// Pixel feeder for the motion-estimation PE chain: loads one current block, then scans every candidate of the search window.
// Optional macro ME_FEEDER_CAND_TAG_EN adds candidate index / last-pixel tags aligned with pix_vld_o.
module me_pixel_feeder #(
  parameter int BLK    = 8,
  parameter int SR     = 4,
  parameter int PIX_W  = 8,
  parameter int CRT_AW = 6,
  parameter int REF_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic [CRT_AW-1:0] crt_addr,
  input  logic [PIX_W-1:0]  crt_rdata,
  output logic [REF_AW-1:0] ref_addr,
  input  logic [PIX_W-1:0]  ref_rdata,
  output logic [PIX_W-1:0]  crt_pixel_o,
  output logic [PIX_W-1:0]  pre_pixel_o,
  output logic              crt_keep_o,
  output logic              pix_vld_o,
  output logic              busy_o,
  output logic              done_o
`ifdef ME_FEEDER_CAND_TAG_EN
  ,
  output logic [$clog2((2*SR+1)*(2*SR+1))-1:0] cand_idx_o,
  output logic                                 cand_last_o
`endif
);

  localparam int N     = BLK * BLK;
  localparam int SPAN  = 2 * SR + 1;
  localparam int WIN   = BLK + 2 * SR;
  localparam int RC_W  = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int OFF_W = (SPAN > 1) ? $clog2(SPAN) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} state_t;

  state_t            state, state_n;
  logic              issue;
  logic              start_ok;
  logic              last_pix, last_cand;
  logic [RC_W-1:0]   r, c, r_n, c_n;
  logic [OFF_W-1:0]  cx, cy, cx_n, cy_n;
  logic [REF_AW-1:0] ref_n;
  logic              v1, scan1;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    start_ok  = start && !done_o;
    last_pix  = (r == RC_W'(BLK - 1)) && (c == RC_W'(BLK - 1));
    last_cand = (cx == OFF_W'(SPAN - 1)) && (cy == OFF_W'(SPAN - 1));
    case (state)
      IDLE:  if (start_ok) state_n = LOAD;
      LOAD: begin
        if (!stall) begin
          issue = 1'b1;
          if (crt_addr == CRT_AW'(N - 1)) state_n = SCAN;
        end
      end
      SCAN: begin
        if (!stall) begin
          issue = 1'b1;
          if (last_pix && last_cand) state_n = DRAIN;
        end
      end
      DRAIN: if (!v1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Raster pixel counter inside a candidate, carrying into cx then cy.
  always_comb begin
    r_n  = r;
    c_n  = c;
    cx_n = cx;
    cy_n = cy;
    if (c == RC_W'(BLK - 1)) begin
      c_n = '0;
      if (r == RC_W'(BLK - 1)) begin
        r_n = '0;
        if (cx == OFF_W'(SPAN - 1)) begin
          cx_n = '0;
          cy_n = cy + OFF_W'(1);
        end else begin
          cx_n = cx + OFF_W'(1);
        end
      end else begin
        r_n = r + RC_W'(1);
      end
    end else begin
      c_n = c + RC_W'(1);
    end
    ref_n = REF_AW'((32'(cy_n) + 32'(r_n)) * 32'(WIN) + 32'(cx_n) + 32'(c_n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crt_addr <= '0;
      ref_addr <= '0;
      r        <= '0;
      c        <= '0;
      cx       <= '0;
      cy       <= '0;
    end else if (state == IDLE && start_ok) begin
      crt_addr <= '0;
      ref_addr <= '0;
      r        <= '0;
      c        <= '0;
      cx       <= '0;
      cy       <= '0;
    end else if (issue && state == LOAD) begin
      if (crt_addr != CRT_AW'(N - 1)) crt_addr <= crt_addr + CRT_AW'(1);
    end else if (issue && state == SCAN && !(last_pix && last_cand)) begin
      r        <= r_n;
      c        <= c_n;
      cx       <= cx_n;
      cy       <= cy_n;
      ref_addr <= ref_n;
    end
  end

  // Stage 1 tracks the cycle in which the buffers perform the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      scan1 <= 1'b0;
    end else begin
      v1    <= issue;
      scan1 <= (state == SCAN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_vld_o   <= 1'b0;
      done_o      <= 1'b0;
      crt_pixel_o <= '0;
      pre_pixel_o <= '0;
      crt_keep_o  <= 1'b0;
    end else begin
      pix_vld_o <= v1;
      done_o    <= (state == DRAIN) && !v1;
      if (v1) begin
        crt_pixel_o <= scan1 ? '0 : crt_rdata;
        pre_pixel_o <= scan1 ? ref_rdata : '0;
        crt_keep_o  <= scan1;
      end
    end
  end

`ifdef ME_FEEDER_CAND_TAG_EN
  localparam int CIDX_W = $clog2(SPAN * SPAN);

  logic [CIDX_W-1:0] idx1;
  logic              last1;

  // Tags ride along with the read pipeline so they line up with the pixel they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx1        <= '0;
      last1       <= 1'b0;
      cand_idx_o  <= '0;
      cand_last_o <= 1'b0;
    end else begin
      idx1  <= (state == SCAN) ? CIDX_W'(32'(cy) * 32'(SPAN) + 32'(cx)) : '0;
      last1 <= (state == SCAN) && last_pix;
      if (v1) begin
        cand_idx_o  <= idx1;
        cand_last_o <= last1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Directed self-checking bench for me_pixel_feeder with BLK=4, SR=1 and identity-content buffers.
// Tag outputs are checked only when ME_FEEDER_CAND_TAG_EN is defined.
module tb_me_pixel_feeder;

  localparam int BLK    = 4;
  localparam int SR     = 1;
  localparam int PIX_W  = 8;
  localparam int CRT_AW = 6;
  localparam int REF_AW = 8;
  localparam int NPIX   = BLK * BLK;
  localparam int SPAN   = 2 * SR + 1;
  localparam int NCAND  = SPAN * SPAN;
  localparam int WIN    = BLK + 2 * SR;
  localparam int TOTAL  = NPIX + NCAND * NPIX;
  localparam int MAXC   = 400;

  logic              clk = 1'b0;
  logic              rst, start, stall;
  logic [CRT_AW-1:0] crtAddr;
  logic [REF_AW-1:0] refAddr;
  logic [PIX_W-1:0]  crtRdata, refRdata;
  logic [PIX_W-1:0]  crtPixel, prePixel;
  logic              crtKeep, pixVld, busy, done;
  logic [6:0]        candIdx;
  logic              candLast;

  int checks   = 0;
  int failures = 0;

  logic       vldLog [MAXC];
  logic       keepLog[MAXC];
  logic       busyLog[MAXC];
  logic       doneLog[MAXC];
  logic [7:0] crtLog [MAXC];
  logic [7:0] preLog [MAXC];
  logic [6:0] idxLog [MAXC];
  logic       lastLog[MAXC];
  logic [7:0] caLog  [MAXC];
  logic [7:0] raLog  [MAXC];

  me_pixel_feeder #(
    .BLK(BLK), .SR(SR), .PIX_W(PIX_W), .CRT_AW(CRT_AW), .REF_AW(REF_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stall(stall),
    .crt_addr(crtAddr),
    .crt_rdata(crtRdata),
    .ref_addr(refAddr),
    .ref_rdata(refRdata),
    .crt_pixel_o(crtPixel),
    .pre_pixel_o(prePixel),
    .crt_keep_o(crtKeep),
    .pix_vld_o(pixVld),
    .busy_o(busy),
    .done_o(done)
`ifdef ME_FEEDER_CAND_TAG_EN
    ,
    .cand_idx_o(candIdx),
    .cand_last_o(candLast)
`endif
  );

`ifndef ME_FEEDER_CAND_TAG_EN
  assign candIdx  = '0;
  assign candLast = 1'b0;
`endif

  always #5 clk = ~clk;

  // Buffers hold their own address as data, with a one-cycle synchronous read.
  always @(posedge clk) begin
    crtRdata <= {2'b00, crtAddr};
    refRdata <= refAddr;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int stallAt, input int stallLen, input int startA,
                               input int startB, input int rstAt, input int ncyc);
    start = 1'b1;
    stall = 1'b0;
    rst   = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk);
      #1;
      vldLog[cyc]  = pixVld;
      keepLog[cyc] = crtKeep;
      busyLog[cyc] = busy;
      doneLog[cyc] = done;
      crtLog[cyc]  = crtPixel;
      preLog[cyc]  = prePixel;
      idxLog[cyc]  = candIdx;
      lastLog[cyc] = candLast;
      caLog[cyc]   = {2'b00, crtAddr};
      raLog[cyc]   = refAddr;
      start = (cyc == startA) || (cyc == startB);
      stall = (cyc >= stallAt) && (cyc < stallAt + stallLen);
      rst   = (cyc == rstAt);
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic checkFrame(input string name, input int lo, input int hi, input int off,
                            input int expBubbles, input int expDone);
    int k, doneCnt, doneAt, firstV, lastV, bubbles;
    int j, ca, p, eCrt, ePre, eKeep, eIdx, eLast;
    k = 0; doneCnt = 0; doneAt = -1; firstV = -1; lastV = -1; bubbles = 0;
    for (int cy = lo; cy <= hi; cy++) begin
      if (doneLog[cy] === 1'b1) begin
        doneCnt++;
        doneAt = cy;
      end
      if (vldLog[cy] === 1'b1) begin
        if (firstV < 0) firstV = cy;
        lastV = cy;
        if (k < NPIX) begin
          eCrt = k; ePre = 0; eKeep = 0; eIdx = 0; eLast = 0;
        end else begin
          j     = k - NPIX;
          ca    = j / NPIX;
          p     = j % NPIX;
          eCrt  = 0;
          ePre  = ((ca / SPAN) + (p / BLK)) * WIN + (ca % SPAN) + (p % BLK);
          eKeep = 1;
          eIdx  = ca;
          eLast = (p == NPIX - 1) ? 1 : 0;
        end
        if (k < TOTAL) begin
          checkOutput($sformatf("%s crt_pixel k=%0d", name, k), crtLog[cy], eCrt);
          checkOutput($sformatf("%s pre_pixel k=%0d", name, k), preLog[cy], ePre);
          checkOutput($sformatf("%s keep k=%0d", name, k), keepLog[cy], eKeep);
`ifdef ME_FEEDER_CAND_TAG_EN
          checkOutput($sformatf("%s cand_idx k=%0d", name, k), idxLog[cy], eIdx);
          checkOutput($sformatf("%s cand_last k=%0d", name, k), lastLog[cy], eLast);
`endif
        end
        k++;
      end else if (firstV >= 0 && k < TOTAL) begin
        bubbles++;
      end
    end
    checkOutput({name, " valid count"}, k, TOTAL);
    checkOutput({name, " first valid cycle"}, firstV, off + 3);
    checkOutput({name, " last valid cycle"}, lastV, expDone - 1);
    checkOutput({name, " bubbles"}, bubbles, expBubbles);
    checkOutput({name, " done count"}, doneCnt, 1);
    checkOutput({name, " done cycle"}, doneAt, expDone);
    checkOutput({name, " busy first issue"}, busyLog[off + 1], 1);
    checkOutput({name, " busy last output"}, busyLog[expDone - 1], 1);
    checkOutput({name, " busy at done"}, busyLog[expDone], 0);
  endtask

  initial begin
    int doneCnt;
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pix_vld", pixVld, 0);
    checkOutput("reset crt_pixel", crtPixel, 0);
    checkOutput("reset pre_pixel", prePixel, 0);
    checkOutput("reset keep", crtKeep, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset crt_addr", crtAddr, 0);
    checkOutput("reset ref_addr", refAddr, 0);
`ifdef ME_FEEDER_CAND_TAG_EN
    checkOutput("reset cand_idx", candIdx, 0);
    checkOutput("reset cand_last", candLast, 0);
`endif

    // start coincident with rst must not launch a frame
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    checkOutput("start with rst busy", busy, 0);
    @(posedge clk);
    #1;
    checkOutput("start with rst busy later", busy, 0);
    checkOutput("start with rst crt_addr", crtAddr, 0);

    $display("[TB] frame without stall");
    applyStimulus(-1, 0, -1, -1, -1, 170);
    checkFrame("plain", 1, 170, 0, 0, 163);
    checkOutput("cand4 first pre", preLog[83], 7);
    checkOutput("cand4 second pre", preLog[84], 8);
    checkOutput("cand4 fifth pre", preLog[87], 13);
    checkOutput("cand4 last pre", preLog[98], 28);
    checkOutput("keep last load", keepLog[18], 0);
    checkOutput("keep first scan", keepLog[19], 1);
`ifdef ME_FEEDER_CAND_TAG_EN
    checkOutput("cand4 idx", idxLog[90], 4);
    checkOutput("cand4 last flag", lastLog[98], 1);
    checkOutput("cand4 not last", lastLog[97], 0);
`endif

    $display("[TB] frame with 3-cycle stall");
    applyStimulus(30, 3, -1, -1, -1, 175);
    checkFrame("stall", 1, 175, 0, 3, 166);
    checkOutput("stall bubble vld", vldLog[33], 0);
    checkOutput("stall held pre", preLog[33], 18);
    checkOutput("stall resumed pre", preLog[35], 19);

    $display("[TB] extra start while busy, then a new frame");
    applyStimulus(-1, 0, 50, 165, -1, 335);
    checkFrame("first", 1, 165, 0, 0, 163);
    checkOutput("keep held before reload", keepLog[167], 1);
    checkOutput("keep cleared at reload", keepLog[168], 0);
    checkFrame("second", 166, 335, 165, 0, 328);

    $display("[TB] reset mid-frame");
    applyStimulus(-1, 0, -1, -1, 40, 200);
    checkOutput("pre-rst keep", keepLog[40], 1);
    checkOutput("post-rst pix_vld", vldLog[41], 0);
    checkOutput("post-rst crt_pixel", crtLog[41], 0);
    checkOutput("post-rst pre_pixel", preLog[41], 0);
    checkOutput("post-rst keep", keepLog[41], 0);
    checkOutput("post-rst busy", busyLog[41], 0);
    checkOutput("post-rst crt_addr", caLog[41], 0);
    checkOutput("post-rst ref_addr", raLog[41], 0);
`ifdef ME_FEEDER_CAND_TAG_EN
    checkOutput("post-rst cand_idx", idxLog[41], 0);
`endif
    doneCnt = 0;
    for (int cy = 1; cy <= 200; cy++) if (doneLog[cy] === 1'b1) doneCnt++;
    checkOutput("post-rst no done", doneCnt, 0);

    $display("[TB] clean frame after reset");
    applyStimulus(-1, 0, -1, -1, -1, 170);
    checkFrame("after rst", 1, 170, 0, 0, 163);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/me_pixel_feeder.md
# me_pixel_feeder

Streams pixels into the motion-estimation PE chain, the driving end of the PE's `crt_pixel` / `pre_pixel` / `crt_keep` interface. On `start`, it reads one current block from the current-block buffer and shifts it into the PEs with `crt_keep` low. It then raises `crt_keep` and streams every candidate block of the reference search window, one pixel per cycle, in a fixed raster order. It sits between the on-chip block/window buffers and the PE array.

## Interface
- BLK, 8, block side in pixels; N = BLK*BLK pixels per block
- SR, 4, search range ±SR; C = (2*SR+1)^2 candidates; WIN = BLK+2*SR window side
- PIX_W, 8, pixel width
- CRT_AW, 6, current-buffer address width, ≥ clog2(N)
- REF_AW, 8, window-buffer address width, ≥ clog2(WIN*WIN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- stall  in  1  freezes address issue while high
- crt_addr  out  CRT_AW  current-buffer read address
- crt_rdata  in  PIX_W  current-buffer data, 1-cycle synchronous read
- ref_addr  out  REF_AW  window-buffer read address
- ref_rdata  in  PIX_W  window-buffer data, 1-cycle synchronous read
- crt_pixel_o  out  PIX_W  current pixel to the PE chain
- pre_pixel_o  out  PIX_W  reference pixel to the PE chain
- crt_keep_o  out  1  0 = PEs shift in current pixels; 1 = PEs hold them
- pix_vld_o  out  1  pixel outputs valid this cycle
- busy_o  out  1  high from the first issue cycle through the last output cycle
- done_o  out  1  one-cycle pulse after the last output pixel
- cand_idx_o  out  clog2(C)  candidate index of the current output pixel (macro-gated)
- cand_last_o  out  1  marks the last pixel of a candidate (macro-gated)

## Operation
- FSM states: IDLE, LOAD, SCAN, DRAIN.
  - IDLE to LOAD on start.
  - LOAD to SCAN after N issues.
  - SCAN to DRAIN after C*N issues.
  - DRAIN to IDLE once the 2-stage pipe is empty; done_o pulses on that transition.
- LOAD: issue crt_addr = 0..N-1 in order.
  - Outputs: crt_pixel_o = crt_rdata, pre_pixel_o = 0, crt_keep_o = 0.
- SCAN: candidate (cy, cx) with cy outer, cx inner, both 0..2*SR.
  - cand_idx = cy*(2*SR+1) + cx; motion vector = (cx-SR, cy-SR).
  - Within a candidate, pixel (r, c) in raster order: ref_addr = (cy+r)*WIN + (cx+c).
  - Outputs: pre_pixel_o = ref_rdata, crt_pixel_o = 0, crt_keep_o = 1.
- crt_keep_o stays 1 after done until the next start's first LOAD output, so the PEs retain the block.
- Stall: while stall = 1, counters and addresses hold; the corresponding output cycle has pix_vld_o = 0 and the pixel outputs hold their values. Stall is ignored in IDLE and DRAIN.
- start is ignored while busy_o = 1 or done_o = 1.
- rst at any time forces IDLE, clears all counters, and drives every output to its reset value the next cycle. An in-flight frame is abandoned and no done_o is produced.
- Counters: pixel counter 0..N-1 wraps at the candidate boundary; cx wraps to 0 with cy+1; address arithmetic is unsigned, no saturation.

## Timing
- Reset values: crt_addr = 0, ref_addr = 0, crt_pixel_o = 0, pre_pixel_o = 0, crt_keep_o = 0, pix_vld_o = 0, busy_o = 0, done_o = 0, cand_idx_o = 0, cand_last_o = 0.
- Latency is 2 cycles from address issue to output: memory read (1) plus output register (1).
- With no stall, start sampled at cycle 0:
  - Issue cycles run 1..N+C*N.
  - LOAD outputs appear cycles 3..N+2.
  - SCAN outputs appear cycles N+3..N+C*N+2.
  - busy_o is high cycles 1..N+C*N+2.
  - done_o pulses at cycle N+C*N+3.
- Each stall cycle during LOAD/SCAN delays every later event by exactly one cycle.
- crt_keep_o switches 0→1 on the first SCAN output cycle, never between valid pixels of the same phase.
- A start in the same cycle as rst is ignored.

## Configuration
- ME_FEEDER_CAND_TAG_EN
  - Defined: cand_idx_o and cand_last_o exist and are registered aligned with pix_vld_o. cand_last_o = 1 on pixel N-1 of each candidate; both are 0 in LOAD.
  - Undefined: both ports and their pipeline registers are absent; all other behaviour is identical.

## Test plan
Setup for all scenarios: BLK=4, SR=1 (N=16, C=9, WIN=6); crt buffer word k = k; ref buffer word a = a.
- Single start, no stall → 16 LOAD outputs crt_pixel_o = 0..15 at cycles 3..18 with keep = 0; SCAN outputs cycles 19..162 with keep = 1; done_o at cycle 163.
- Candidate 4 (cy=1, cx=1) → pre_pixel_o = 7, 8, 9, 10, 13, …, 28; cand_idx_o = 4; cand_last_o on value 28.
- stall high for 3 cycles at cycle 30 → exactly 3 pix_vld_o = 0 bubbles; the pixel sequence is unchanged; done_o at cycle 166.
- start pulsed again at cycle 50 → ignored; single done_o; a start at cycle 165 begins a new frame with keep = 1 held until cycle 168.
- rst at cycle 40 → all outputs 0 at cycle 41; no done_o; a following start produces a clean full frame.
- Build without ME_FEEDER_CAND_TAG_EN → same pixel, keep and done timing as the first scenario.
